bram_fifo_ctrl: RTL and testbench
=================================

Name: bram_fifo_ctrl

Overview:
Single-clock FIFO controller that drives the simple-dual-port block-RAM wrapper (DI/DO, WRADDR/RDADDR, WREN/RDEN, WE, REGCE) and turns it into a 2^ADDR_W-entry FIFO. It sits directly upstream of the BRAM and generates all of its address, enable and data-in signals. It consumes the BRAM's DO and realigns it with a valid strobe that accounts for the BRAM read latency. Producers and consumers see only push/pop, full/empty and count.

Parameters:
DATA_W, 8, FIFO and BRAM data width
ADDR_W, 6, BRAM address width; depth = 2^ADDR_W = 64
RD_LAT, 2, BRAM read latency in cycles: 1 = DO unregistered, 2 = DO output register enabled
AFULL_TH, 60, almost_full asserted when count >= AFULL_TH

Ports:
clk  in  1  system clock; also drives BRAM RDCLK and WRCLK
RST  in  1  synchronous, active-high reset
wr_en  in  1  push request
wr_data  in  DATA_W  push data
full  out  1  no free entry
almost_full  out  1  count >= AFULL_TH
rd_en  in  1  pop request
rd_data  out  DATA_W  popped data, valid when rd_valid
rd_valid  out  1  rd_data carries the word popped RD_LAT cycles earlier
empty  out  1  no stored entry
count  out  ADDR_W+1  number of stored entries, 0..2^ADDR_W
bram_wraddr  out  ADDR_W  to BRAM WRADDR
bram_wren  out  1  to BRAM WREN
bram_we  out  1  to BRAM WE, equal to bram_wren
bram_di  out  DATA_W  to BRAM DI
bram_rdaddr  out  ADDR_W  to BRAM RDADDR
bram_rden  out  1  to BRAM RDEN
bram_regce  out  1  to BRAM REGCE
bram_do  in  DATA_W  from BRAM DO

Behaviour:
- One clock (clk). Reset is synchronous and active-high (RST).
- Pointers: wptr and rptr are ADDR_W+1 bits each. The MSB is the wrap bit.
  - empty = (wptr == rptr)
  - full = (MSBs differ and low ADDR_W bits equal)
  - count = wptr - rptr, modulo 2^(ADDR_W+1)
- Push accept: push_ok = wr_en & ~full, using registered full from the current cycle.
  - Combinational: bram_wren = bram_we = push_ok, bram_wraddr = wptr[ADDR_W-1:0], bram_di = wr_data.
  - wptr increments at the clock edge.
- Pop accept: pop_ok = rd_en & ~empty.
  - Combinational: bram_rden = pop_ok, bram_rdaddr = rptr[ADDR_W-1:0].
  - rptr increments at the clock edge.
- Read pipeline: pop_ok feeds an RD_LAT-deep valid shift register.
  - rd_valid is high exactly RD_LAT cycles after each accepted pop.
  - rd_data = bram_do as a passthrough; the BRAM provides the latency.
- bram_regce: tied to 1 when RD_LAT=2. Unused (driven 1) when RD_LAT=1.
- Flags full, empty, almost_full and count are registered. They update the cycle after the push/pop edge.
- Simultaneous push and pop, neither full nor empty: both accepted, count unchanged.
- Push while full: dropped, no BRAM write, pointers unchanged.
  - If a pop is accepted in the same cycle, the push is still dropped.
  - full deasserts next cycle.
- Pop while empty: ignored, bram_rden=0, no rd_valid generated.
  - A simultaneous push is accepted, and empty deasserts next cycle.
- Wrap-around: the low address bits wrap 63→0. The wrap bit toggles, and full/empty stay correct across any number of wraps.
- Read/write collision: a pop only reads occupied entries, so the same-address read and write never occur in one cycle.
- Reset: RST held for one cycle returns the block to its empty state.
  - wptr = rptr = 0, count = 0, empty = 1, full = 0, almost_full = 0.
  - The valid pipeline is cleared, so rd_valid = 0 and any in-flight read is discarded.
  - bram_wren = bram_rden = 0 while RST = 1.
  - RST has priority over wr_en and rd_en.
  - BRAM contents are not cleared.

Optional Feature:
FIFO_ERR_FLAGS_EN
- With the macro defined, the block adds:
  - output ovf: sticky, set the cycle after a push is attempted while full.
  - output udf: sticky, set the cycle after a pop is attempted while empty.
  - Both clear only on RST.
- Without the macro, ovf and udf do not exist. There is no extra logic, and dropped pushes and pops are silent.

Test Plan:
- Reset, then push 0x11, 0x22, 0x33 → count=3 and empty=0. Pop three times with RD_LAT=2 → rd_valid high on cycles +2, +3, +4 with rd_data 0x11, 0x22, 0x33.
- Push 64 words 0x00..0x3F → full=1, almost_full=1 from count=60, count=64. A 65th push with 0xAA → bram_wren=0 and count stays 64 (ovf=1 if enabled).
- Pop from empty after reset → bram_rden=0 and rd_valid stays 0 (udf=1 if enabled). A simultaneous push of 0x5A is accepted, count=1.
- Fill 40 words, then 200 cycles of simultaneous push/pop with an incrementing pattern → count constant at 40, pointers wrap ≥3 times, output sequence in order with no gaps.
- With the FIFO full, issue push 0xBB and pop together → pop yields the oldest word, push dropped, count=63 next cycle.
- Pop issued, RST asserted the following cycle → rd_valid never asserts for that pop, count=0, empty=1. Subsequent push/pop of 0xC3 → 0xC3 returned.

Source files
------------

// File: rtl/bram_fifo_ctrl.sv
// -----------------------------------------------------------------------------
// bram_fifo_ctrl
//
// Purpose:
//   Single-clock FIFO controller for a simple-dual-port block RAM. It generates
//   every BRAM write/read address, enable and data-in signal, and it tracks the
//   fill level with wrap-bit pointers. It also produces a valid strobe that
//   lines up with the BRAM's read latency. Producers and consumers only see
//   push/pop, full/empty and count.
//
// Parameters:
//   DATA_W   - data width of the FIFO and the BRAM
//   ADDR_W   - BRAM address width; the depth is 2**ADDR_W
//   RD_LAT   - BRAM read latency: 1 = DO unregistered, 2 = DO output register
//   AFULL_TH - almost_full is asserted when count >= AFULL_TH
//
// Ports:
//   clk          in   system clock (also the BRAM read and write clock)
//   RST          in   synchronous, active-high reset
//   wr_en        in   push request
//   wr_data      in   push data
//   full         out  no free entry (registered)
//   almost_full  out  count >= AFULL_TH (registered)
//   rd_en        in   pop request
//   rd_data      out  popped data, qualified by rd_valid (passthrough of DO)
//   rd_valid     out  high RD_LAT cycles after each accepted pop
//   empty        out  no stored entry (registered)
//   count        out  number of stored entries, 0..2**ADDR_W (registered)
//   bram_wraddr  out  BRAM WRADDR
//   bram_wren    out  BRAM WREN
//   bram_we      out  BRAM WE, always equal to bram_wren
//   bram_di      out  BRAM DI
//   bram_rdaddr  out  BRAM RDADDR
//   bram_rden    out  BRAM RDEN
//   bram_regce   out  BRAM REGCE (held at 1)
//   bram_do      in   BRAM DO
//
// Optional feature (macro FIFO_ERR_FLAGS_EN):
//   The macro adds two sticky error outputs, ovf and udf. ovf records a push
//   attempted while full. udf records a pop attempted while empty. Only RST
//   clears them. When the macro is undefined, these ports and their logic do
//   not exist.
// -----------------------------------------------------------------------------
module bram_fifo_ctrl #(
    parameter int DATA_W   = 8,
    parameter int ADDR_W   = 6,
    parameter int RD_LAT   = 2,
    parameter int AFULL_TH = 60
) (
    input  logic              clk,
    input  logic              RST,
    input  logic              wr_en,
    input  logic [DATA_W-1:0] wr_data,
    output logic              full,
    output logic              almost_full,
    input  logic              rd_en,
    output logic [DATA_W-1:0] rd_data,
    output logic              rd_valid,
    output logic              empty,
    output logic [ADDR_W:0]   count,
    output logic [ADDR_W-1:0] bram_wraddr,
    output logic              bram_wren,
    output logic              bram_we,
    output logic [DATA_W-1:0] bram_di,
    output logic [ADDR_W-1:0] bram_rdaddr,
    output logic              bram_rden,
    output logic              bram_regce,
    input  logic [DATA_W-1:0] bram_do
`ifdef FIFO_ERR_FLAGS_EN
    ,
    output logic              ovf,
    output logic              udf
`endif
);

    localparam int PTR_W = ADDR_W + 1;
    localparam logic [PTR_W-1:0] AFULL_TH_P = PTR_W'(AFULL_TH);
    localparam logic [PTR_W-1:0] PTR_ONE    = PTR_W'(1);

    // Pointer and flag state
    logic [PTR_W-1:0]  wptr_q, wptr_d;
    logic [PTR_W-1:0]  rptr_q, rptr_d;
    logic [PTR_W-1:0]  count_q, count_d;
    logic              full_q, full_d;
    logic              empty_q, empty_d;
    logic              afull_q, afull_d;

    // Read-valid pipeline: bit 0 is set at the edge that accepts a pop
    logic [RD_LAT-1:0] valid_q, valid_d;

    // Accept strobes for the current cycle
    logic              push_ok;
    logic              pop_ok;

`ifdef FIFO_ERR_FLAGS_EN
    logic              ovf_q, ovf_d;
    logic              udf_q, udf_d;
`endif

    // Accept decision: uses the registered flags, and reset blocks all traffic
    always_comb begin
        push_ok = 1'b0;
        pop_ok  = 1'b0;
        if (RST) begin
            push_ok = 1'b0;
            pop_ok  = 1'b0;
        end else begin
            push_ok = wr_en & ~full_q;
            pop_ok  = rd_en & ~empty_q;
        end
    end

    // BRAM port drive: the write and read sides come straight from the pointers
    always_comb begin
        bram_wren   = push_ok;
        bram_we     = push_ok;
        bram_wraddr = wptr_q[ADDR_W-1:0];
        bram_di     = wr_data;
        bram_rden   = pop_ok;
        bram_rdaddr = rptr_q[ADDR_W-1:0];
        // The BRAM output register (if present) simply follows its latch each
        // cycle; rd_valid alone qualifies which DO words are meaningful.
        bram_regce  = 1'b1;
    end

    // Next pointer values: each pointer advances by one on an accepted access
    always_comb begin
        wptr_d = wptr_q;
        rptr_d = rptr_q;
        if (push_ok) begin
            wptr_d = wptr_q + PTR_ONE;
        end else begin
            wptr_d = wptr_q;
        end
        if (pop_ok) begin
            rptr_d = rptr_q + PTR_ONE;
        end else begin
            rptr_d = rptr_q;
        end
    end

    // Next flag values, taken from the next pointers so that they line up
    // with the pointer update
    always_comb begin
        count_d = wptr_d - rptr_d;
        empty_d = (wptr_d == rptr_d);
        // Same slot but a different wrap bit means the writer is one lap ahead
        full_d  = (wptr_d[ADDR_W] != rptr_d[ADDR_W]) &&
                  (wptr_d[ADDR_W-1:0] == rptr_d[ADDR_W-1:0]);
        afull_d = (count_d >= AFULL_TH_P);
    end

    // Next read-valid pipeline: shift the accepted-pop strobe toward the output
    always_comb begin
        valid_d    = valid_q;
        valid_d[0] = pop_ok;
        for (int i = 1; i < RD_LAT; i++) begin
            valid_d[i] = valid_q[i-1];
        end
    end

`ifdef FIFO_ERR_FLAGS_EN
    // Next sticky error flags: record any request the FIFO had to drop
    always_comb begin
        ovf_d = ovf_q;
        udf_d = udf_q;
        if (wr_en && full_q) begin
            ovf_d = 1'b1;
        end else begin
            ovf_d = ovf_q;
        end
        if (rd_en && empty_q) begin
            udf_d = 1'b1;
        end else begin
            udf_d = udf_q;
        end
    end

    // Sticky error flag registers, cleared only by reset
    always_ff @(posedge clk) begin
        if (RST) begin
            ovf_q <= 1'b0;
            udf_q <= 1'b0;
        end else begin
            ovf_q <= ovf_d;
            udf_q <= udf_d;
        end
    end

    assign ovf = ovf_q;
    assign udf = udf_q;
`endif

    // Pointer and flag registers; reset returns the FIFO to empty
    always_ff @(posedge clk) begin
        if (RST) begin
            wptr_q  <= {PTR_W{1'b0}};
            rptr_q  <= {PTR_W{1'b0}};
            count_q <= {PTR_W{1'b0}};
            full_q  <= 1'b0;
            empty_q <= 1'b1;
            afull_q <= 1'b0;
        end else begin
            wptr_q  <= wptr_d;
            rptr_q  <= rptr_d;
            count_q <= count_d;
            full_q  <= full_d;
            empty_q <= empty_d;
            afull_q <= afull_d;
        end
    end

    // Read-valid pipeline register; reset discards reads that are in flight
    always_ff @(posedge clk) begin
        if (RST) begin
            valid_q <= {RD_LAT{1'b0}};
        end else begin
            valid_q <= valid_d;
        end
    end

    // Consumer-side outputs: the BRAM supplies the data latency, so DO passes
    // straight through and the pipeline tail qualifies it
    always_comb begin
        rd_data     = bram_do;
        rd_valid    = valid_q[RD_LAT-1];
        full        = full_q;
        empty       = empty_q;
        almost_full = afull_q;
        count       = count_q;
    end

endmodule

// File: tb/tb_bram_fifo_ctrl.sv
// -----------------------------------------------------------------------------
// tb_bram_fifo_ctrl
//
// Testbench for bram_fifo_ctrl. A behavioural simple-dual-port BRAM with an
// output register (RD_LAT = 2) is attached to the controller. A queue-based
// reference model predicts occupancy, flags, BRAM strobes and addresses, and
// the popped data stream. Directed scenarios run first, followed by randomized
// traffic.
// -----------------------------------------------------------------------------
module tb_bram_fifo_ctrl;

    localparam int DATA_W   = 8;
    localparam int ADDR_W   = 6;
    localparam int RD_LAT   = 2;
    localparam int AFULL_TH = 60;
    localparam int DEPTH    = 64;

    logic              clk;
    logic              RST;
    logic              wr_en;
    logic [DATA_W-1:0] wr_data;
    logic              full;
    logic              almost_full;
    logic              rd_en;
    logic [DATA_W-1:0] rd_data;
    logic              rd_valid;
    logic              empty;
    logic [ADDR_W:0]   count;
    logic [ADDR_W-1:0] bram_wraddr;
    logic              bram_wren;
    logic              bram_we;
    logic [DATA_W-1:0] bram_di;
    logic [ADDR_W-1:0] bram_rdaddr;
    logic              bram_rden;
    logic              bram_regce;
    logic [DATA_W-1:0] bram_do;
`ifdef FIFO_ERR_FLAGS_EN
    logic              ovf;
    logic              udf;
`endif

    bram_fifo_ctrl #(
        .DATA_W(DATA_W), .ADDR_W(ADDR_W), .RD_LAT(RD_LAT), .AFULL_TH(AFULL_TH)
    ) dut (
        .clk(clk), .RST(RST),
        .wr_en(wr_en), .wr_data(wr_data), .full(full), .almost_full(almost_full),
        .rd_en(rd_en), .rd_data(rd_data), .rd_valid(rd_valid), .empty(empty),
        .count(count),
        .bram_wraddr(bram_wraddr), .bram_wren(bram_wren), .bram_we(bram_we),
        .bram_di(bram_di), .bram_rdaddr(bram_rdaddr), .bram_rden(bram_rden),
        .bram_regce(bram_regce), .bram_do(bram_do)
`ifdef FIFO_ERR_FLAGS_EN
        , .ovf(ovf), .udf(udf)
`endif
    );

    // Behavioural BRAM: a synchronous read latch followed by the DO output register
    logic [DATA_W-1:0] mem [DEPTH];
    logic [DATA_W-1:0] rd_latch;
    logic [DATA_W-1:0] do_reg;

    always @(posedge clk) begin
        if (bram_wren && bram_we) mem[bram_wraddr] <= bram_di;
        if (bram_rden) rd_latch <= mem[bram_rdaddr];
        if (bram_regce) do_reg <= rd_latch;
    end
    assign bram_do = do_reg;

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int checks   = 0;
    int failures = 0;

    // Reference model state
    logic [DATA_W-1:0] mq [$];     // stored words, oldest first
    int                due_q [$];  // cycle in which each popped word must appear
    logic [DATA_W-1:0] dat_q [$];  // the popped words themselves
    int                wtot = 0;   // accepted pushes since reset
    int                rtot = 0;   // accepted pops since reset
    int                cyc  = 0;
    logic              m_ovf = 1'b0;
    logic              m_udf = 1'b0;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=0x%0h expected=0x%0h (cycle %0d)", tag, obs, exp, cyc);
        end
    endtask

    // One clock cycle: drive inputs, compare every output with the model, then
    // advance the model as the coming edge will
    task automatic step(input logic w, input logic [DATA_W-1:0] d,
                        input logic r, input logic rs);
        logic push_exp;
        logic pop_exp;
        logic v_exp;
        @(negedge clk);
        cyc++;
        wr_en   = w;
        wr_data = d;
        rd_en   = r;
        RST     = rs;
        #1;
        check("count", 32'(count), 32'(mq.size()));
        check("empty", 32'(empty), 32'(mq.size() == 0));
        check("full", 32'(full), 32'(mq.size() == DEPTH));
        check("almost_full", 32'(almost_full), 32'(mq.size() >= AFULL_TH));
`ifdef FIFO_ERR_FLAGS_EN
        check("ovf", 32'(ovf), 32'(m_ovf));
        check("udf", 32'(udf), 32'(m_udf));
`endif
        push_exp = !rs && w && (mq.size() < DEPTH);
        pop_exp  = !rs && r && (mq.size() > 0);
        check("bram_wren", 32'(bram_wren), 32'(push_exp));
        check("bram_we", 32'(bram_we), 32'(push_exp));
        check("bram_rden", 32'(bram_rden), 32'(pop_exp));
        check("bram_regce", 32'(bram_regce), 32'h1);
        if (push_exp) begin
            check("bram_wraddr", 32'(bram_wraddr), 32'(wtot % DEPTH));
            check("bram_di", 32'(bram_di), 32'(d));
        end
        if (pop_exp) check("bram_rdaddr", 32'(bram_rdaddr), 32'(rtot % DEPTH));
        if (!rs) begin
            v_exp = (due_q.size() > 0) && (due_q[0] == cyc);
            check("rd_valid", 32'(rd_valid), 32'(v_exp));
            if (v_exp) begin
                check("rd_data", 32'(rd_data), 32'(dat_q[0]));
                void'(due_q.pop_front());
                void'(dat_q.pop_front());
            end
        end
        if (rs) begin
            mq.delete();
            due_q.delete();
            dat_q.delete();
            wtot  = 0;
            rtot  = 0;
            m_ovf = 1'b0;
            m_udf = 1'b0;
        end else begin
            if (w && mq.size() == DEPTH) m_ovf = 1'b1;
            if (r && mq.size() == 0) m_udf = 1'b1;
            if (pop_exp) begin
                due_q.push_back(cyc + RD_LAT);
                dat_q.push_back(mq.pop_front());
                rtot++;
            end
            if (push_exp) begin
                mq.push_back(d);
                wtot++;
            end
        end
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) step(1'b0, 8'h00, 1'b0, 1'b0);
    endtask

    initial begin
        RST     = 1'b1;
        wr_en   = 1'b0;
        rd_en   = 1'b0;
        wr_data = 8'h00;
        repeat (2) @(posedge clk);

        // Reset state, then three pushes and three pops
        step(1'b0, 8'h00, 1'b0, 1'b0);
        step(1'b1, 8'h11, 1'b0, 1'b0);
        step(1'b1, 8'h22, 1'b0, 1'b0);
        step(1'b1, 8'h33, 1'b0, 1'b0);
        step(1'b0, 8'h00, 1'b0, 1'b0);
        for (int i = 0; i < 3; i++) step(1'b0, 8'h00, 1'b1, 1'b0);
        idle(4);

        // Fill to 64 words, push 0xAA while full, then push 0xBB with a pop
        step(1'b0, 8'h00, 1'b0, 1'b1);
        for (int i = 0; i < 64; i++) step(1'b1, 8'(i), 1'b0, 1'b0);
        step(1'b1, 8'hAA, 1'b0, 1'b0);
        step(1'b1, 8'hBB, 1'b1, 1'b0);
        idle(3);

        // Pop from empty while a push of 0x5A arrives
        step(1'b0, 8'h00, 1'b0, 1'b1);
        step(1'b1, 8'h5A, 1'b1, 1'b0);
        step(1'b0, 8'h00, 1'b0, 1'b0);
        step(1'b0, 8'h00, 1'b1, 1'b0);
        idle(3);

        // Hold 40 words while streaming 200 push/pop pairs through the wrap
        step(1'b0, 8'h00, 1'b0, 1'b1);
        for (int i = 0; i < 40; i++) step(1'b1, 8'(i), 1'b0, 1'b0);
        for (int i = 0; i < 200; i++) step(1'b1, 8'(40 + i), 1'b1, 1'b0);
        idle(2);

        // A pop followed immediately by reset, then a round trip of 0xC3
        step(1'b0, 8'h00, 1'b1, 1'b0);
        step(1'b0, 8'h00, 1'b0, 1'b1);
        idle(3);
        step(1'b1, 8'hC3, 1'b0, 1'b0);
        step(1'b0, 8'h00, 1'b1, 1'b0);
        idle(3);

        // Randomized traffic with fill/drain biases and occasional resets
        for (int seg = 0; seg < 4; seg++) begin
            int wb;
            int rb;
            wb = (seg == 0) ? 85 : (seg == 1) ? 20 : 55;
            rb = (seg == 0) ? 20 : (seg == 1) ? 85 : 50;
            for (int i = 0; i < 300; i++) begin
                step(($urandom_range(0, 99) < wb), 8'($urandom),
                     ($urandom_range(0, 99) < rb), ($urandom_range(0, 299) == 0));
            end
        end
        idle(4);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
